// File: rtl/tc_rom_byte_streamer.sv
// tc_rom_byte_streamer
// Reads a file out of a combinational, byte-addressed ROM and streams it one byte per
// valid/ready handshake. Address all-ones returns the file length. Each 64-bit ROM word holds
// eight bytes, little-endian. The length is clamped to MAX_BYTES.
//
// Every output is registered and loaded on the edge that enters the state it belongs to.
// Because of this, the ROM address and the stream outputs are stable for the whole cycle
// in which they are used.

module tc_rom_byte_streamer #(
    parameter int unsigned     UUID      = 0,
    parameter string           NAME      = "",
    parameter longint unsigned MAX_BYTES = 64'd65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        rom_en,
    output logic [63:0] rom_address,
    input  logic [63:0] rom_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [63:0] byte_count
);

    // A zero clamp would make every transfer empty, so reject it at elaboration.
    if (MAX_BYTES == 0) begin : g_bad_max_bytes
        $error("tc_rom_byte_streamer %s (uuid %0d): MAX_BYTES must be non-zero", NAME, UUID);
    end

    typedef enum logic [2:0] {
        StIdle,
        StSize,
        StFetch,
        StStream,
        StDone
    } state_e;

    localparam logic [63:0] MaxLen   = 64'(MAX_BYTES);
    localparam logic [63:0] LenQuery = '1;

    state_e      state_q;
    logic [63:0] len_q;
    logic [63:0] ptr_q;
    logic [63:0] word_q;
    logic [2:0]  idx_q;

    logic [63:0] len_clamped;
    logic        handshake;
    logic [2:0]  idx_next;
    logic [63:0] ptr_next;
    logic [63:0] last_ptr;

    // Derived values used by the state machine.
    always_comb begin
        len_clamped = (rom_data > MaxLen) ? MaxLen : rom_data;
        handshake   = out_valid && out_ready;
        idx_next    = idx_q + 3'd1;
        ptr_next    = ptr_q + 64'd1;
        last_ptr    = len_q - 64'd1;
    end

    // Transfer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            ptr_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            rom_en      <= 1'b0;
            rom_address <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            byte_count  <= '0;
        end else if (abort && (state_q != StIdle)) begin
            // Abort drops everything in flight but keeps the count of bytes already accepted.
            state_q     <= StIdle;
            rom_en      <= 1'b0;
            rom_address <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StSize;
                        byte_count  <= '0;
                        rom_en      <= 1'b1;
                        rom_address <= LenQuery;
                        busy        <= 1'b1;
                    end
                end

                StSize: begin
                    len_q       <= len_clamped;
                    ptr_q       <= '0;
                    rom_address <= '0;
                    if (len_clamped == 64'd0) begin
                        state_q <= StDone;
                        rom_en  <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        // The first word starts at address 0, and rom_en stays high.
                        state_q <= StFetch;
                    end
                end

                StFetch: begin
                    word_q      <= rom_data;
                    idx_q       <= '0;
                    state_q     <= StStream;
                    rom_en      <= 1'b0;
                    rom_address <= '0;
                    out_valid   <= 1'b1;
                    out_data    <= rom_data[7:0];
                    out_last    <= (ptr_q == last_ptr);
                end

                StStream: begin
                    // When there is no handshake, every output keeps its value.
                    if (handshake) begin
                        ptr_q      <= ptr_next;
                        idx_q      <= idx_next;
                        byte_count <= byte_count + 64'd1;
                        if (out_last) begin
                            state_q   <= StDone;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            done      <= 1'b1;
                        end else if (idx_q == 3'd7) begin
                            state_q     <= StFetch;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            out_data    <= '0;
                            rom_en      <= 1'b1;
                            rom_address <= ptr_next;
                        end else begin
                            out_data <= word_q[8*idx_next +: 8];
                            out_last <= (ptr_next == last_ptr);
                        end
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_rom_byte_streamer.sv
// tb_tc_rom_byte_streamer
// Table of whole transfers, each with a hand-computed byte count and done latency.
// Hand-written sequences cover abort, reset mid-stream, start held high and restart.
// Instance a uses the default clamp; instance b uses MAX_BYTES = 4.

module tb_tc_rom_byte_streamer;

    localparam int ROM_DEPTH = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic        sel;
    logic [63:0] rom_len;
    logic        start_a;
    logic        start_b;

    logic        a_rom_en, a_out_valid, a_out_last, a_busy, a_done;
    logic [63:0] a_rom_address, a_rom_data, a_byte_count;
    logic [7:0]  a_out_data;
    logic        b_rom_en, b_out_valid, b_out_last, b_busy, b_done;
    logic [63:0] b_rom_address, b_rom_data, b_byte_count;
    logic [7:0]  b_out_data;

    // View of the instance selected by sel.
    logic        v, l, dn, bsy, ren;
    logic [7:0]  d;
    logic [63:0] bc, raddr;

    int n_tests = 0;
    int n_fail  = 0;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    // ROM model: byte i holds i below ROM_DEPTH and 0 above; address all-ones returns the length.
    function automatic logic [63:0] rom_read(input logic en, input logic [63:0] addr,
                                             input logic [63:0] flen);
        logic [63:0] w;
        logic [63:0] b;
        w = '0;
        if (!en) return '0;
        if (addr == '1) return flen;
        for (int i = 0; i < 8; i++) begin
            b = addr + 64'(i);
            if (b < 64'(ROM_DEPTH)) w[8*i +: 8] = b[7:0];
        end
        return w;
    endfunction

    always_comb a_rom_data = rom_read(a_rom_en, a_rom_address, rom_len);
    always_comb b_rom_data = rom_read(b_rom_en, b_rom_address, rom_len);

    always_comb begin
        if (sel) begin
            v = b_out_valid; l = b_out_last; dn = b_done; bsy = b_busy; ren = b_rom_en;
            d = b_out_data; bc = b_byte_count; raddr = b_rom_address;
        end else begin
            v = a_out_valid; l = a_out_last; dn = a_done; bsy = a_busy; ren = a_rom_en;
            d = a_out_data; bc = a_byte_count; raddr = a_rom_address;
        end
    end

    tc_rom_byte_streamer #(.UUID(1), .NAME("full"), .MAX_BYTES(64'd65536)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .rom_en(a_rom_en), .rom_address(a_rom_address), .rom_data(a_rom_data),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_last(a_out_last), .busy(a_busy), .done(a_done), .byte_count(a_byte_count)
    );

    tc_rom_byte_streamer #(.UUID(2), .NAME("clamp4"), .MAX_BYTES(64'd4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .rom_en(b_rom_en), .rom_address(b_rom_address), .rom_data(b_rom_data),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_last(b_out_last), .busy(b_busy), .done(b_done), .byte_count(b_byte_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        use_clamp;
        logic [63:0] rom_len;
        int          ready_mode;   // 0: always ready, 1: ready on odd cycles only
        int          exp_bytes;
        int          exp_done_lat; // edges from the start edge to the cycle with done high
    } vec_t;

    vec_t vecs[11];

    // Runs one transfer. Each byte is checked at its handshake and each stall is checked
    // for stable outputs.
    task automatic run_vec(input vec_t t, input int n);
        int          lat, nb, first_v, data_err, last_err, stall_err;
        logic        stalled, rdy, hold_l;
        logic [7:0]  hold_d, exp_byte;
        string       tag;
        tag = $sformatf("vec%0d", n);
        nb = 0; first_v = 0; data_err = 0; last_err = 0; stall_err = 0;
        stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
        sel = t.use_clamp;
        rom_len = t.rom_len;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check({tag, " size rom_en"}, 64'(ren), 64'd1);
        check({tag, " size address"}, raddr, '1);
        while (!dn && lat < 400) begin
            rdy = (t.ready_mode == 1) ? ((lat % 2) == 1) : 1'b1;
            out_ready = rdy;
            if (stalled && (!v || d !== hold_d || l !== hold_l)) stall_err++;
            if (v) begin
                if (first_v == 0) first_v = lat;
                if (rdy) begin
                    exp_byte = (nb < ROM_DEPTH) ? 8'(nb) : 8'h00;
                    if (d !== exp_byte) data_err++;
                    if (l !== (nb == t.exp_bytes - 1)) last_err++;
                    nb++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d  = d;
                    hold_l  = l;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b1;
        check({tag, " done latency"}, 64'(lat), 64'(t.exp_done_lat));
        check({tag, " bytes streamed"}, 64'(nb), 64'(t.exp_bytes));
        check({tag, " first valid cycle"}, 64'(first_v), (t.exp_bytes > 0) ? 64'd3 : 64'd0);
        check({tag, " byte data errors"}, 64'(data_err), 64'd0);
        check({tag, " last flag errors"}, 64'(last_err), 64'd0);
        check({tag, " stall stability errors"}, 64'(stall_err), 64'd0);
        check({tag, " byte_count"}, bc, 64'(t.exp_bytes));
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(dn), 64'd0);
        check({tag, " idle busy"}, 64'(bsy), 64'd0);
    endtask

    initial begin
        int lat, dones;

        vecs[0]  = '{1'b0, 64'd12, 0, 12, 16};
        vecs[1]  = '{1'b0, 64'd8,  0, 8,  11};
        vecs[2]  = '{1'b0, 64'd0,  0, 0,  2};
        vecs[3]  = '{1'b0, 64'd1,  0, 1,  4};
        vecs[4]  = '{1'b0, 64'd9,  0, 9,  13};
        vecs[5]  = '{1'b0, 64'd16, 0, 16, 20};
        vecs[6]  = '{1'b0, 64'd5,  1, 5,  12};
        vecs[7]  = '{1'b1, 64'd10, 0, 4,  7};
        vecs[8]  = '{1'b1, 64'd3,  0, 3,  6};
        vecs[9]  = '{1'b1, 64'd0,  0, 0,  2};
        vecs[10] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4, 7};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; sel = 1'b0; rom_len = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(v), 64'd0);
        check("reset busy", 64'(bsy), 64'd0);
        check("reset done", 64'(dn), 64'd0);
        check("reset rom_en", 64'(ren), 64'd0);
        check("reset byte_count", bc, 64'd0);
        check("reset out_data", 64'(d), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Abort after the second byte is accepted.
        sel = 1'b0; rom_len = 64'd12; out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort pre byte_count", bc, 64'd2);
        check("abort pre data", 64'(d), 64'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort out_valid", 64'(v), 64'd0);
        check("abort busy", 64'(bsy), 64'd0);
        check("abort byte_count", bc, 64'd2);
        dones = 0;
        if (dn) dones++;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dn) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        check("abort byte_count held", bc, 64'd2);

        // Reset in the middle of streaming clears every output.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-rst byte_count", bc, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", 64'(v), 64'd0);
        check("rst out_data", 64'(d), 64'd0);
        check("rst out_last", 64'(l), 64'd0);
        check("rst busy", 64'(bsy), 64'd0);
        check("rst rom_en", 64'(ren), 64'd0);
        check("rst rom_address", raddr, 64'd0);
        check("rst byte_count", bc, 64'd0);

        // Start held high through most of the stream, then a clean restart.
        @(negedge clk); start = 1'b1;
        @(negedge clk); lat = 1;
        while (!dn && lat < 400) begin
            if (lat == 14) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("held-start done latency", 64'(lat), 64'd16);
        check("held-start byte_count", bc, 64'd12);
        @(negedge clk);
        check("held-start idle", 64'(bsy), 64'd0);
        rom_len = 64'd5;
        start = 1'b1;
        @(negedge clk); start = 1'b0; lat = 1;
        check("restart byte_count cleared", bc, 64'd0);
        while (!dn && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("restart done latency", 64'(lat), 64'd8);
        check("restart byte_count", bc, 64'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
